fbindct_pipe: RTL and testbench
===============================

FBINDCT_PIPE -- requirements
Module: fbindct_pipe

Interface
REQ-001 Parameter IN_W, default 8, meaning signed input sample width (4..16).
REQ-002 Parameter OUT_W, default IN_W+4, meaning signed coefficient width for all internal and output signals.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 srstn  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous pipeline clear.
REQ-006 in_valid  input  1  x_in holds a valid 8-sample vector.
REQ-007 in_ready  output  1  stage 1 accepts the vector this cycle.
REQ-008 x_in  input  8 x IN_W signed  samples x0..x7.
REQ-009 out_valid  output  1  x_out holds a valid coefficient vector.
REQ-010 out_ready  input  1  consumer accepts x_out this cycle.
REQ-011 x_out  output  8 x OUT_W signed  coefficients X0..X7.

Function
REQ-012 Arithmetic: all terms sign-extended to OUT_W; every lifting term floor(n*z/2^s) SHALL be computed as (n*z)>>>s, an arithmetic shift, which floors toward minus infinity.
REQ-013 S1: a_k = x_k + x_(7-k) for k=0..3; a4=x3-x4, a5=x2-x5, a6=x1-x6, a7=x0-x7.
REQ-014 S2: b0=a0+a3, b1=a1+a2, b2=a1-a2, b3=a0-a3; s1=a6-floor(13*a5/32), s2=a5+floor(11*s1/16), s3=s1-floor(13*s2/32); a4 and a7 pass through.
REQ-015 S3: X0=b0+b1, X4=floor(X0/2)-b1, c6=b2-floor(13*b3/32), X2=b3+floor(11*c6/32), X6=c6; e4=a4+s2, e5=a4-s2, e6=a7-s3, e7=a7+s3.
REQ-016 S4: X1=e7+floor(3*e4/16), X7=e4-floor(3*X1/16), X5=e5+floor(7*e6/8), X3=e6-floor(e5/2); the even coefficients pass through.
REQ-017 Each of S1..S4 ends in a register with its own valid bit; the S4 register drives x_out and out_valid directly.
REQ-018 Latency: a vector accepted in cycle n appears on x_out with out_valid=1 in cycle n+4 when out_ready is held at 1.
REQ-019 Throughput: one vector per cycle while out_ready=1.
REQ-020 A stage register loads when its own valid bit is 0 or when the downstream stage loads in the same cycle (bubble-collapsing).
REQ-021 in_ready = S1 load condition; it has no combinational dependence on in_valid.
REQ-022 While out_valid=1 and out_ready=0, x_out and out_valid SHALL hold stable.
REQ-023 When full with out_ready=0, the pipeline holds exactly 4 vectors; no vector is lost or duplicated.
REQ-024 flush=1 clears all four valid bits at the next edge; a vector presented in that cycle is not accepted (in_ready=0), and flush overrides in_valid.
REQ-025 For IN_W-bit full-range inputs, no intermediate SHALL overflow OUT_W = IN_W+4.

Reset
REQ-026 srstn=0 SHALL asynchronously clear all valid bits, giving out_valid=0 and in_ready=1 after release.
REQ-027 Data registers are cleared to 0 on reset, so x_out=0 during and after reset until the first valid vector.
REQ-028 A reset asserted mid-operation discards all in-flight vectors, and no stale vector appears after release.

Structure
REQ-029 Package bindct_pkg holds the lifting constants (13/32, 11/16, 13/32, 13/32, 11/32, 3/16, 3/16, 7/8, 1/2 as numerator/shift pairs) and the OUT_W default function.
REQ-030 Sub-module bindct_lift implements a single lifting step, y = x +/- ((n*z)>>>s), with n, s and sign as parameters; each lifting step of REQ-014..REQ-016 is an instance of it.

Verification
REQ-031 Reset test: all x=10, out_ready=1 -> X0=80, X1..X7=0 at cycle n+4.
REQ-032 Impulse test: x0=1, all other samples 0 -> X0..X7 = {1,1,1,1,0,0,0,0}.
REQ-033 Floor-rounding test: x7=1, all other samples 0 -> X0..X7 = {1,-1,1,-1,0,-1,0,1}.
REQ-034 Extreme-value test: all x=-128 (IN_W=8) -> X0=-1024, others 0, with no wrap.
REQ-035 Backpressure test: 20 random vectors with out_ready toggled randomly -> outputs in order and bit-exact against a golden model, x_out stable while stalled, in_ready=0 only when 4 vectors are held.
REQ-036 Flush/reset test: flush, then srstn=0, each applied with 3 vectors in flight -> out_valid=0 next cycle, no old vector emitted afterwards, and the next vector appears with 4-cycle latency.

Source files
------------

// File: rtl/bindct_pkg.sv
// Shared constants for the 8-point binDCT lifting pipeline: lifting multipliers
// as numerator / right-shift pairs and the default coefficient width.
package bindct_pkg;

  localparam int LIFT_S1_N = 13;  localparam int LIFT_S1_S = 5;
  localparam int LIFT_S2_N = 11;  localparam int LIFT_S2_S = 4;
  localparam int LIFT_S3_N = 13;  localparam int LIFT_S3_S = 5;
  localparam int LIFT_C6_N = 13;  localparam int LIFT_C6_S = 5;
  localparam int LIFT_X2_N = 11;  localparam int LIFT_X2_S = 5;
  localparam int LIFT_X1_N = 3;   localparam int LIFT_X1_S = 4;
  localparam int LIFT_X7_N = 3;   localparam int LIFT_X7_S = 4;
  localparam int LIFT_X5_N = 7;   localparam int LIFT_X5_S = 3;
  localparam int LIFT_X3_N = 1;   localparam int LIFT_X3_S = 1;

  // Four guard bits cover the worst-case growth of the 8-point sum.
  function automatic int out_w_default(input int in_w);
    return in_w + 4;
  endfunction

endpackage

// File: rtl/bindct_lift.sv
// One lifting step: y = x +/- floor(n*z / 2^s), floor via arithmetic shift.
module bindct_lift #(
  parameter int W   = 12,
  parameter int N   = 1,
  parameter int S   = 0,
  parameter bit SUB = 1'b0
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] z,
  output logic signed [W-1:0] y
);

  // Product is widened so n*z never wraps before the shift brings it back in range.
  localparam int PW = W + 5;

  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] term_s;

  // Scaled, floored lifting term added to or subtracted from x
  always_comb begin
    prod_s = PW'(z) * PW'(N);
    term_s = prod_s >>> S;
    if (SUB) begin
      y = x - term_s[W-1:0];
    end else begin
      y = x + term_s[W-1:0];
    end
  end

endmodule

// File: rtl/fbindct_pipe.sv
// Four-stage 8-point forward binDCT with valid/ready handshake and
// bubble-collapsing stage registers; x_out/out_valid come straight from stage 4.
module fbindct_pipe import bindct_pkg::*; #(
  parameter int IN_W  = 8,
  parameter int OUT_W = out_w_default(IN_W)
) (
  input  logic                   clk,
  input  logic                   srstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0][IN_W-1:0]   x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0][OUT_W-1:0]  x_out
);

  typedef logic signed [OUT_W-1:0] coef_t;

  coef_t x_s [8];
  coef_t a_s [8];
  coef_t a_r [8];
  coef_t b_s [8];   // b0 b1 b2 b3 a4 s2 s3 a7
  coef_t b_r [8];
  coef_t c_s [8];   // X0 X4 X2 X6 e4 e5 e6 e7
  coef_t c_r [8];
  coef_t d_s [8];   // X0..X7
  coef_t x0_s;
  coef_t s1_s, s2_s, s3_s, c6_s, x2_s, x1_s, x7_s, x5_s, x3_s;

  logic v1_r, v2_r, v3_r;
  logic ld1_s, ld2_s, ld3_s, ld4_s;

  // A stage loads when empty or when the stage after it is loading
  always_comb begin
    ld4_s    = !out_valid || out_ready;
    ld3_s    = !v3_r || ld4_s;
    ld2_s    = !v2_r || ld3_s;
    ld1_s    = !v1_r || ld2_s;
    in_ready = ld1_s && !flush;
  end

  // Stage 1 butterflies on sign-extended samples
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      x_s[k] = OUT_W'($signed(x_in[k]));
    end
    for (int k = 0; k < 4; k++) begin
      a_s[k]     = x_s[k] + x_s[7-k];
      a_s[7-k]   = x_s[k] - x_s[7-k];
    end
  end

  bindct_lift #(.W(OUT_W), .N(LIFT_S1_N), .S(LIFT_S1_S), .SUB(1'b1)) u_s1 (.x(a_r[6]), .z(a_r[5]), .y(s1_s));
  bindct_lift #(.W(OUT_W), .N(LIFT_S2_N), .S(LIFT_S2_S), .SUB(1'b0)) u_s2 (.x(a_r[5]), .z(s1_s),   .y(s2_s));
  bindct_lift #(.W(OUT_W), .N(LIFT_S3_N), .S(LIFT_S3_S), .SUB(1'b1)) u_s3 (.x(s1_s),   .z(s2_s),   .y(s3_s));

  // Stage 2 even butterflies plus odd rotation lifting chain
  always_comb begin
    b_s[0] = a_r[0] + a_r[3];
    b_s[1] = a_r[1] + a_r[2];
    b_s[2] = a_r[1] - a_r[2];
    b_s[3] = a_r[0] - a_r[3];
    b_s[4] = a_r[4];
    b_s[5] = s2_s;
    b_s[6] = s3_s;
    b_s[7] = a_r[7];
  end

  bindct_lift #(.W(OUT_W), .N(LIFT_C6_N), .S(LIFT_C6_S), .SUB(1'b1)) u_c6 (.x(b_r[2]), .z(b_r[3]), .y(c6_s));
  bindct_lift #(.W(OUT_W), .N(LIFT_X2_N), .S(LIFT_X2_S), .SUB(1'b0)) u_x2 (.x(b_r[3]), .z(c6_s),   .y(x2_s));

  // Stage 3 even outputs and odd butterflies
  always_comb begin
    x0_s   = b_r[0] + b_r[1];
    c_s[0] = x0_s;
    c_s[1] = (x0_s >>> 1) - b_r[1];
    c_s[2] = x2_s;
    c_s[3] = c6_s;
    c_s[4] = b_r[4] + b_r[5];
    c_s[5] = b_r[4] - b_r[5];
    c_s[6] = b_r[7] - b_r[6];
    c_s[7] = b_r[7] + b_r[6];
  end

  bindct_lift #(.W(OUT_W), .N(LIFT_X1_N), .S(LIFT_X1_S), .SUB(1'b0)) u_x1 (.x(c_r[7]), .z(c_r[4]), .y(x1_s));
  bindct_lift #(.W(OUT_W), .N(LIFT_X7_N), .S(LIFT_X7_S), .SUB(1'b1)) u_x7 (.x(c_r[4]), .z(x1_s),   .y(x7_s));
  bindct_lift #(.W(OUT_W), .N(LIFT_X5_N), .S(LIFT_X5_S), .SUB(1'b0)) u_x5 (.x(c_r[5]), .z(c_r[6]), .y(x5_s));
  bindct_lift #(.W(OUT_W), .N(LIFT_X3_N), .S(LIFT_X3_S), .SUB(1'b1)) u_x3 (.x(c_r[6]), .z(c_r[5]), .y(x3_s));

  // Stage 4 reorders into natural coefficient order
  always_comb begin
    d_s[0] = c_r[0];
    d_s[1] = x1_s;
    d_s[2] = c_r[2];
    d_s[3] = x3_s;
    d_s[4] = c_r[1];
    d_s[5] = x5_s;
    d_s[6] = c_r[3];
    d_s[7] = x7_s;
  end

  // Stage valids and data; data only moves with a valid vector so x_out stays 0 until the first one
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      v3_r      <= 1'b0;
      out_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        c_r[k]   <= '0;
        x_out[k] <= '0;
      end
    end else if (flush) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      v3_r      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (ld1_s) v1_r      <= in_valid;
      if (ld2_s) v2_r      <= v1_r;
      if (ld3_s) v3_r      <= v2_r;
      if (ld4_s) out_valid <= v3_r;
      if (ld1_s && in_valid) a_r <= a_s;
      if (ld2_s && v1_r)     b_r <= b_s;
      if (ld3_s && v2_r)     c_r <= c_s;
      if (ld4_s && v3_r) begin
        for (int k = 0; k < 8; k++) begin
          x_out[k] <= d_s[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fbindct_pipe.sv
// Directed and table-driven bench for fbindct_pipe (IN_W=8, OUT_W=12).
module tb_fbindct_pipe;

  logic              clk;
  logic              srstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [7:0][7:0]   x_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0][11:0]  x_out;

  int n_pass;
  int n_total;

  fbindct_pipe #(.IN_W(8)) dut (
    .clk(clk), .srstn(srstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [7:0][7:0]  x;
    logic [7:0][11:0] y;
  } vec_t;

  task automatic chkb(input string n, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", n, act, exp);
  endtask

  task automatic chkv(input string n, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic chki(input string n, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][7:0] mkx(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [7:0][7:0] r;
    r[0] = 8'(v0); r[1] = 8'(v1); r[2] = 8'(v2); r[3] = 8'(v3);
    r[4] = 8'(v4); r[5] = 8'(v5); r[6] = 8'(v6); r[7] = 8'(v7);
    return r;
  endfunction

  function automatic logic [7:0][11:0] mky(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [7:0][11:0] r;
    r[0] = 12'(v0); r[1] = 12'(v1); r[2] = 12'(v2); r[3] = 12'(v3);
    r[4] = 12'(v4); r[5] = 12'(v5); r[6] = 12'(v6); r[7] = 12'(v7);
    return r;
  endfunction

  // Reference transform written directly from the lifting equations in integer arithmetic
  function automatic logic [7:0][11:0] golden(input logic [7:0][7:0] x);
    int xi [8];
    int a [8];
    int b0, b1, b2, b3, s1, s2, s3, c6, e4, e5, e6, e7, y0, y1, y2, y3, y4, y5, y6, y7;
    for (int k = 0; k < 8; k++) xi[k] = int'($signed(x[k]));
    for (int k = 0; k < 4; k++) begin
      a[k] = xi[k] + xi[7-k];
      a[7-k] = xi[k] - xi[7-k];
    end
    b0 = a[0] + a[3]; b1 = a[1] + a[2]; b2 = a[1] - a[2]; b3 = a[0] - a[3];
    s1 = a[6] - ((13 * a[5]) >>> 5);
    s2 = a[5] + ((11 * s1) >>> 4);
    s3 = s1 - ((13 * s2) >>> 5);
    y0 = b0 + b1;
    y4 = (y0 >>> 1) - b1;
    c6 = b2 - ((13 * b3) >>> 5);
    y2 = b3 + ((11 * c6) >>> 5);
    y6 = c6;
    e4 = a[4] + s2; e5 = a[4] - s2; e6 = a[7] - s3; e7 = a[7] + s3;
    y1 = e7 + ((3 * e4) >>> 4);
    y7 = e4 - ((3 * y1) >>> 4);
    y5 = e5 + ((7 * e6) >>> 3);
    y3 = e6 - (e5 >>> 1);
    return mky(y0, y1, y2, y3, y4, y5, y6, y7);
  endfunction

  // Present one vector into an empty pipeline and check exact 4-cycle latency and data
  task automatic send_check(input string n, input logic [7:0][7:0] x, input logic [7:0][11:0] y);
    in_valid = 1'b1;
    x_in     = x;
    #1;
    chkb({n, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chkb({n, "_early"}, out_valid, 1'b0);
    tick();
    chkb({n, "_valid"}, out_valid, 1'b1);
    chkv({n, "_data"}, x_out, y);
    tick();
  endtask

  vec_t             tbl [6];
  logic [7:0][7:0]  vecs [20];
  logic [7:0][11:0] expq [$];
  logic [95:0]      held_x;
  logic             stall_prev;
  int               sent, got, stale;

  initial begin
    n_pass = 0; n_total = 0;
    tbl[0] = '{"all10",   mkx(10, 10, 10, 10, 10, 10, 10, 10),         mky(80, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{"impulse", mkx(1, 0, 0, 0, 0, 0, 0, 0),                 mky(1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[2] = '{"floor_x7", mkx(0, 0, 0, 0, 0, 0, 0, 1),                mky(1, -1, 1, -1, 0, -1, 0, 1)};
    tbl[3] = '{"min_all", mkx(-128, -128, -128, -128, -128, -128, -128, -128), mky(-1024, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4] = '{"max_all", mkx(127, 127, 127, 127, 127, 127, 127, 127), mky(1016, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5] = '{"x3_only", mkx(0, 0, 0, 1, 0, 0, 0, 0),                 mky(1, 0, -1, 0, 0, 1, 1, 1)};

    srstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
    #3 srstn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkv("rst_x_out", x_out, 96'd0);
    srstn = 1'b1;
    #1;
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid_after", out_valid, 1'b0);
    tick();

    for (int i = 0; i < 6; i++) begin
      send_check(tbl[i].name, tbl[i].x, tbl[i].y);
    end

    // Random traffic with random backpressure against the reference model
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) vecs[i][k] = 8'($urandom_range(0, 255));
    end
    sent = 0; got = 0; stall_prev = 1'b0; held_x = '0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x_in     = vecs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        chkb("bp_stall_valid", out_valid, 1'b1);
        chkv("bp_stall_data", x_out, held_x);
      end
      chkb("bp_in_ready", in_ready, !(expq.size() == 4 && !out_ready));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chki("bp_unexpected_output", 1, 0);
        end else begin
          chkv("bp_data", x_out, expq.pop_front());
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held_x     = x_out;
      if (in_valid && in_ready) begin
        expq.push_back(golden(vecs[sent]));
        sent++;
      end
      tick();
    end
    chki("bp_all_received", got, 20);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Flush with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x_in = vecs[i];
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; x_in = vecs[3];
    #1;
    chkb("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chkb("flush_out_valid", out_valid, 1'b0);
    stale = 0;
    repeat (6) begin
      tick();
      if (out_valid) stale++;
    end
    chki("flush_no_stale", stale, 0);
    send_check("post_flush", tbl[2].x, tbl[2].y);

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x_in = vecs[i + 4];
      tick();
    end
    in_valid = 1'b0;
    srstn = 1'b0;
    #1;
    chkb("mid_rst_out_valid", out_valid, 1'b0);
    chkv("mid_rst_x_out", x_out, 96'd0);
    tick();
    srstn = 1'b1;
    #1;
    chkb("mid_rst_in_ready", in_ready, 1'b1);
    stale = 0;
    repeat (6) begin
      tick();
      if (out_valid) stale++;
    end
    chki("rst_no_stale", stale, 0);
    send_check("post_rst", tbl[5].x, tbl[5].y);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
